// File: rtl/sdram_az_responder_if.sv
// rtl/sdram_az_responder_if.sv - request/response bundle between an AZ-style master and the SDRAM responder
interface sdram_az_responder_if;
    logic [23:0] az_addr;
    logic [3:0]  az_be_n;
    logic        az_cs;
    logic [31:0] az_data;
    logic        az_rd_n;
    logic        az_wr_n;
    logic [31:0] za_data;
    logic        za_valid;
    logic        za_waitrequest;
    logic        proto_err;

    modport master (
        output az_addr, az_be_n, az_cs, az_data, az_rd_n, az_wr_n,
        input  za_data, za_valid, za_waitrequest, proto_err
    );

    modport slave (
        input  az_addr, az_be_n, az_cs, az_data, az_rd_n, az_wr_n,
        output za_data, za_valid, za_waitrequest, proto_err
    );
endinterface

// File: rtl/sdram_az_responder.sv
// rtl/sdram_az_responder.sv - word-addressed memory responder with write wait states and pipelined reads
module sdram_az_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int READ_LAT  = 2,
    parameter int MAX_PEND  = 2,
    parameter int WR_WAIT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_az_responder_if.slave  bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(MAX_PEND) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [2:0]     r_cnt;
    logic [2:0]     w_cnt_next;
    logic [PW-1:0]  r_pend_cnt;
    logic [READ_LAT-1:0] r_pv;
    logic [31:0]    r_pd [READ_LAT];
    logic [31:0]    r_mem [MEM_WORDS];
    logic           r_proto_err;

    logic           w_wr_req;
    logic           w_rd_req;
    logic           w_both;
    logic           w_wr_acc;
    logic           w_wr_ok;
    logic           w_rd_acc;
    logic           w_ret;
    logic           w_pend_full;
    logic           w_waitreq;
    logic [AW-1:0]  w_idx;
    logic           w_unused;

    // a simultaneous read+write is treated as a write; the read half is dropped
    assign w_wr_req    = bus.az_cs & ~bus.az_wr_n;
    assign w_rd_req    = bus.az_cs & ~bus.az_rd_n & bus.az_wr_n;
    assign w_both      = bus.az_cs & ~bus.az_rd_n & ~bus.az_wr_n;
    assign w_idx       = bus.az_addr[AW+1:2];
    assign w_pend_full = (r_pend_cnt == PW'(MAX_PEND));
    assign w_ret       = r_pv[READ_LAT-1];
    assign w_rd_acc    = w_rd_req & (r_state == S_IDLE) & ~w_pend_full & ~rst;
    assign w_wr_ok     = w_wr_acc & ~rst;
    assign w_unused    = &{1'b0, bus.az_addr[23:AW+2], bus.az_addr[1:0]};

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_wr_acc   = 1'b0;
        w_waitreq  = w_pend_full;
        case (r_state)
            S_IDLE: begin
                if (w_wr_req) begin
                    if (WR_WAIT == 0) begin
                        w_wr_acc  = 1'b1;
                        w_waitreq = 1'b0;
                    end else begin
                        w_waitreq  = 1'b1;
                        w_cnt_next = 3'(WR_WAIT);
                        w_next     = (WR_WAIT == 1) ? S_ACK : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_waitreq = 1'b1;
                if (!w_wr_req) begin
                    w_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                    if (r_cnt == 3'd2) begin
                        w_next = S_ACK;
                    end
                end
            end
            S_ACK: begin
                w_next = S_IDLE;
                if (w_wr_req) begin
                    w_waitreq = 1'b0;
                    w_wr_acc  = 1'b1;
                end else begin
                    w_waitreq = w_rd_req | w_pend_full;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_pend_cnt  <= '0;
            r_pv        <= '0;
            r_proto_err <= 1'b0;
            for (int k = 0; k < READ_LAT; k++) begin
                r_pd[k] <= 32'd0;
            end
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            // data stages only advance behind a valid entry so the output word holds between returns
            r_pv[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_pd[0] <= r_mem[w_idx];
            end
            for (int k = 1; k < READ_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                if (r_pv[k-1]) begin
                    r_pd[k] <= r_pd[k-1];
                end
            end
            case ({w_rd_acc, w_ret})
                2'b10:   r_pend_cnt <= r_pend_cnt + PW'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - PW'(1);
                default: r_pend_cnt <= r_pend_cnt;
            endcase
            if (w_both) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.az_be_n[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.az_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.za_valid       = w_ret;
    assign bus.za_data        = r_pd[READ_LAT-1];
    assign bus.za_waitrequest = w_waitreq & ~rst;
    assign bus.proto_err      = r_proto_err;
endmodule

// File: tb/tb_sdram_az_responder.sv
// tb/tb_sdram_az_responder.sv - scoreboard bench over three latency/pending configurations
module tb_sdram_az_responder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] s_addr [3];
    logic [3:0]  s_be_n [3];
    logic        s_cs   [3];
    logic [31:0] s_data [3];
    logic        s_rd_n [3];
    logic        s_wr_n [3];
    logic [31:0] o_data [3];
    logic        o_valid[3];
    logic        o_wait [3];
    logic        o_perr [3];

    // instance 0: READ_LAT 2 / MAX_PEND 2, instance 1: 1 / 1, instance 2: 4 / 2
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sdram_az_responder_if u_if ();
        assign u_if.az_addr = s_addr[g];
        assign u_if.az_be_n = s_be_n[g];
        assign u_if.az_cs   = s_cs[g];
        assign u_if.az_data = s_data[g];
        assign u_if.az_rd_n = s_rd_n[g];
        assign u_if.az_wr_n = s_wr_n[g];
        assign o_data[g]    = u_if.za_data;
        assign o_valid[g]   = u_if.za_valid;
        assign o_wait[g]    = u_if.za_waitrequest;
        assign o_perr[g]    = u_if.proto_err;
        sdram_az_responder #(
            .MEM_WORDS (1024),
            .READ_LAT  ((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
            .MAX_PEND  ((g == 1) ? 1 : 2),
            .WR_WAIT   (1)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if.slave)
        );
    end

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (o_valid[d]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 32'(d), 32'hFFFF_FFFF);
                    end else begin
                        m_e = q.pop_front();
                        chk("rd_inst", 32'(d), 32'(m_e.inst));
                        chk("rd_data", o_data[d], m_e.data);
                        chk("rd_lat", 32'(cyc), 32'(m_e.due));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int d = 0; d < 3; d++) begin
            s_cs[d] = 1'b0; s_rd_n[d] = 1'b1; s_wr_n[d] = 1'b1;
        end
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input int d, input logic [23:0] a, input logic [31:0] v,
                      input logic [3:0] be, input int exp_w, input bit rd_too);
        int  w;
        bit  acc;
        w = 0; acc = 0;
        s_addr[d] = a; s_data[d] = v; s_be_n[d] = be;
        s_cs[d] = 1'b1; s_wr_n[d] = 1'b0; s_rd_n[d] = rd_too ? 1'b0 : 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!o_wait[d]) begin acc = 1; break; end
            w++;
            @(posedge clk); #1;
        end
        if (!acc) chk("wr_timeout", 32'd0, 32'd1);
        chk("wr_wait", 32'(w), 32'(exp_w));
        @(posedge clk); #1;
        s_cs[d] = 1'b0; s_wr_n[d] = 1'b1; s_rd_n[d] = 1'b1;
    endtask

    task automatic rd(input int d, input logic [23:0] a, input logic [31:0] v,
                      input int exp_w, input bit push);
        int  w;
        bit  acc;
        w = 0; acc = 0;
        s_addr[d] = a; s_cs[d] = 1'b1; s_rd_n[d] = 1'b0; s_wr_n[d] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!o_wait[d]) begin
                acc = 1;
                if (push) q.push_back('{d, v, cyc + lat(d)});
                break;
            end
            w++;
            @(posedge clk); #1;
        end
        if (!acc) chk("rd_timeout", 32'd0, 32'd1);
        if (exp_w >= 0) chk("rd_wait", 32'(w), 32'(exp_w));
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            s_addr[d] = '0; s_be_n[d] = 4'hF; s_data[d] = '0;
            s_cs[d] = 1'b0; s_rd_n[d] = 1'b1; s_wr_n[d] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", 32'(o_valid[0]), 32'd0);
        chk("rst_data",  o_data[0], 32'd0);
        chk("rst_wait",  32'(o_wait[0]), 32'd0);
        chk("rst_perr",  32'(o_perr[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // basic write with one wait state, then readback
        wr(0, 24'h000010, 32'hDEADBEEF, 4'b0000, 1, 0);
        rd(0, 24'h000010, 32'hDEADBEEF, 0, 1);
        idle(4);

        // byte-lane merge and an all-disabled write
        wr(0, 24'h000020, 32'hFFFFFFFF, 4'b0000, 1, 0);
        wr(0, 24'h000020, 32'h11223344, 4'b1010, 1, 0);
        wr(0, 24'h000020, 32'h00000000, 4'b1111, 1, 0);
        rd(0, 24'h000020, 32'hFF22FF44, 0, 1);
        idle(4);

        // three back-to-back reads against MAX_PEND=2
        wr(0, 24'h000000, 32'hA0A0A0A0, 4'b0000, 1, 0);
        wr(0, 24'h000004, 32'hA1A1A1A1, 4'b0000, 1, 0);
        wr(0, 24'h000008, 32'hA2A2A2A2, 4'b0000, 1, 0);
        rd(0, 24'h000000, 32'hA0A0A0A0, 0, 1);
        rd(0, 24'h000004, 32'hA1A1A1A1, 0, 1);
        rd(0, 24'h000008, 32'hA2A2A2A2, 1, 1);
        idle(6);

        // chip select low: nothing recognised
        s_cs[0] = 1'b0; s_rd_n[0] = 1'b0; s_wr_n[0] = 1'b0;
        @(negedge clk);
        chk("cs_low_wait", 32'(o_wait[0]), 32'd0);
        @(posedge clk); #1;
        idle(4);

        // reset with two reads in flight on the 4-cycle instance
        wr(2, 24'h000010, 32'hCAFEF00D, 4'b0000, 1, 0);
        rd(2, 24'h000010, 32'h0, 0, 0);
        rd(2, 24'h000010, 32'h0, 0, 0);
        idle(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(8);
        rd(2, 24'h000010, 32'hCAFEF00D, 0, 1);
        idle(6);

        // reset while a write is still waiting abandons it
        wr(0, 24'h000030, 32'h12345678, 4'b0000, 1, 0);
        s_addr[0] = 24'h000030; s_data[0] = 32'h99999999; s_be_n[0] = 4'b0000;
        s_cs[0] = 1'b1; s_wr_n[0] = 1'b0;
        @(negedge clk);
        chk("wait_before_rst", 32'(o_wait[0]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        rd(0, 24'h000030, 32'h12345678, 0, 1);
        idle(4);
        chk("perr_clear", 32'(o_perr[0]), 32'd0);

        // read and write both low: write only, sticky protocol error
        wr(0, 24'h000040, 32'hA5A5A5A5, 4'b0000, 1, 1);
        idle(5);
        chk("perr_set", 32'(o_perr[0]), 32'd1);
        rd(0, 24'h000040, 32'hA5A5A5A5, 0, 1);
        idle(4);
        chk("perr_sticky", 32'(o_perr[0]), 32'd1);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        chk("perr_rst", 32'(o_perr[0]), 32'd0);
        @(posedge clk); #1;

        // write-then-read of word 5 on every latency
        wr(0, 24'h000014, 32'h5555AAAA, 4'b0000, 1, 0);
        rd(0, 24'h000014, 32'h5555AAAA, 0, 1);
        idle(4);
        wr(1, 24'h000014, 32'h01020304, 4'b0000, 1, 0);
        rd(1, 24'h000014, 32'h01020304, 0, 1);
        rd(1, 24'h000014, 32'h01020304, 1, 1);
        idle(4);
        wr(2, 24'h000014, 32'h0BADCAFE, 4'b0000, 1, 0);
        rd(2, 24'h000014, 32'h0BADCAFE, 0, 1);
        rd(2, 24'h000014, 32'h0BADCAFE, 0, 1);
        rd(2, 24'h000014, 32'h0BADCAFE, 3, 1);
        idle(10);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
